// File: rtl/dlsc_pcie_s6_pkg.sv
// Shared definitions for the PCIe outbound read allocator: FSM states,
// default sizing and the tag/buffer credit check.
package dlsc_pcie_s6_pkg;

    typedef enum logic [1:0] {
        ST_INIT  = 2'd0,
        ST_IDLE  = 2'd1,
        ST_ALLOC = 2'd2,
        ST_REQ   = 2'd3
    } alloc_state_t;

    localparam int TAGS       = 32;
    localparam int BUF_DWORDS = 512;

    // True when one more tag is free and the region of 'need' dwords fits.
    // Operands are widened to 32 bits so the sums cannot overflow.
    function automatic logic credit_ok(
        input logic [31:0] tag_used,
        input logic [31:0] tags,
        input logic [31:0] data_used,
        input logic [31:0] need,
        input logic [31:0] buf_dwords
    );
        return (tag_used < tags) && ((data_used + need) <= buf_dwords);
    endfunction

endpackage

// File: rtl/dlsc_pcie_s6_credit_counter.sv
// Up-by-N / down-by-1 credit counter. Both directions apply in the same
// cycle; a release with nothing outstanding saturates at zero.
module dlsc_pcie_s6_credit_counter #(
    parameter int W     = 6,
    parameter int INC_W = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc_en,
    input  logic [INC_W-1:0] inc_amt,
    input  logic             dec,
    output logic [W-1:0]     count
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;
    logic [W:0]   sum_s;

    // Next count: add the allocation, then remove one released unit
    always_comb begin
        sum_s   = {1'b0, count_q};
        count_d = count_q;
        if (inc_en) begin
            sum_s = {1'b0, count_q} + (W+1)'(inc_amt);
        end else begin
            sum_s = {1'b0, count_q};
        end
        if (dec) begin
            if (sum_s == {(W+1){1'b0}}) begin
                count_d = {W{1'b0}};
            end else begin
                count_d = W'(sum_s - (W+1)'(1'b1));
            end
        end else begin
            count_d = W'(sum_s);
        end
    end

    // Count register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= {W{1'b0}};
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

    dlsc_pcie_s6_credit_counter_chk #(.W(W)) u_chk (
        .clk    (clk),
        .rst    (rst),
        .inc_en (inc_en),
        .dec    (dec),
        .count  (count_q)
    );

endmodule

// File: rtl/dlsc_pcie_s6_credit_counter_chk.sv
// Simulation checker: a release must never arrive while the count is zero.
module dlsc_pcie_s6_credit_counter_chk #(
    parameter int W = 6
) (
    input logic         clk,
    input logic         rst,
    input logic         inc_en,
    input logic         dec,
    input logic [W-1:0] count
);

    a_no_underflow: assert property (@(posedge clk) disable iff (rst)
        !(dec && !inc_en && (count == {W{1'b0}})));

endmodule

// File: rtl/dlsc_pcie_s6_outbound_read_alloc.sv
// Outbound read allocator: reserves one tag and a contiguous buffer region
// per read command, then issues the memory-read request. Tags and regions
// are handed out strictly in order and recycled by buffer feedback.
module dlsc_pcie_s6_outbound_read_alloc
    import dlsc_pcie_s6_pkg::*;
#(
    parameter int ADDR = 32,
    parameter int LEN  = 4,
    parameter int TAG  = $clog2(TAGS),
    parameter int BUFA = $clog2(BUF_DWORDS)
) (
    input  logic              clk,
    input  logic              rst,
    output logic              cmd_ready,
    input  logic              cmd_valid,
    input  logic [ADDR-3:0]   cmd_addr,
    input  logic [LEN-1:0]    cmd_len,
    input  logic              req_ready,
    output logic              req_valid,
    output logic [ADDR-3:0]   req_addr,
    output logic [LEN:0]      req_len,
    output logic [TAG-1:0]    req_tag,
    output logic              alloc_init,
    output logic              alloc_valid,
    output logic [TAG:0]      alloc_tag,
    output logic [BUFA-1:0]   alloc_bufa,
    input  logic              dealloc_tag,
    input  logic              dealloc_data
);

    localparam int N_TAGS = 1 << TAG;
    localparam int N_BUF  = 1 << BUFA;

    alloc_state_t    state_q, state_d;
    logic [ADDR-3:0] addr_q, addr_d;
    logic [LEN-1:0]  len_q, len_d;
    logic [TAG:0]    alloc_tag_q, alloc_tag_d;
    logic [BUFA-1:0] alloc_bufa_q, alloc_bufa_d;

    logic [TAG:0]    tag_used_s;
    logic [BUFA:0]   data_used_s;
    logic [LEN:0]    req_len_s;
    logic            alloc_cycle_s;

    assign req_len_s     = (LEN+1)'(len_q) + (LEN+1)'(1'b1);
    assign alloc_cycle_s = (state_q == ST_ALLOC);

    // Next-state and output decode; alloc_tag only advances once the request is taken
    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        len_d        = len_q;
        alloc_tag_d  = alloc_tag_q;
        alloc_bufa_d = alloc_bufa_q;
        cmd_ready    = 1'b0;
        alloc_valid  = 1'b0;
        req_valid    = 1'b0;
        alloc_init   = 1'b0;
        case (state_q)
            ST_INIT: begin
                alloc_init = 1'b1;
                state_d    = ST_IDLE;
            end
            ST_IDLE: begin
                cmd_ready = credit_ok(32'(tag_used_s), 32'(N_TAGS), 32'(data_used_s),
                                      32'(cmd_len) + 32'd1, 32'(N_BUF));
                if (cmd_valid && cmd_ready) begin
                    addr_d  = cmd_addr;
                    len_d   = cmd_len;
                    state_d = ST_ALLOC;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ALLOC: begin
                alloc_valid = 1'b1;
                state_d     = ST_REQ;
            end
            ST_REQ: begin
                req_valid = 1'b1;
                if (req_ready) begin
                    alloc_tag_d  = alloc_tag_q + (TAG+1)'(1'b1);
                    alloc_bufa_d = alloc_bufa_q + BUFA'(req_len_s);
                    state_d      = ST_IDLE;
                end else begin
                    state_d = ST_REQ;
                end
            end
            default: begin
                state_d = ST_INIT;
            end
        endcase
    end

    // State and allocation registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_INIT;
            addr_q       <= {(ADDR-2){1'b0}};
            len_q        <= {LEN{1'b0}};
            alloc_tag_q  <= {(TAG+1){1'b0}};
            alloc_bufa_q <= {BUFA{1'b0}};
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            len_q        <= len_d;
            alloc_tag_q  <= alloc_tag_d;
            alloc_bufa_q <= alloc_bufa_d;
        end
    end

    assign req_addr   = addr_q;
    assign req_len    = req_len_s;
    assign req_tag    = alloc_tag_q[TAG-1:0];
    assign alloc_tag  = alloc_tag_q;
    assign alloc_bufa = alloc_bufa_q;

    dlsc_pcie_s6_credit_counter #(.W(TAG+1), .INC_W(1)) u_tag_cnt (
        .clk     (clk),
        .rst     (rst),
        .inc_en  (alloc_cycle_s),
        .inc_amt (1'b1),
        .dec     (dealloc_tag),
        .count   (tag_used_s)
    );

    dlsc_pcie_s6_credit_counter #(.W(BUFA+1), .INC_W(LEN+1)) u_data_cnt (
        .clk     (clk),
        .rst     (rst),
        .inc_en  (alloc_cycle_s),
        .inc_amt (req_len_s),
        .dec     (dealloc_data),
        .count   (data_used_s)
    );

endmodule

// File: tb/tb_dlsc_pcie_s6_outbound_read_alloc.sv
// Directed bench for the outbound read allocator (TAG=5, BUFA=8).
module tb_dlsc_pcie_s6_outbound_read_alloc;

    localparam int ADDR = 32;
    localparam int LEN  = 4;
    localparam int TAG  = 5;
    localparam int BUFA = 8;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            cmd_ready;
    logic            cmd_valid = 1'b0;
    logic [29:0]     cmd_addr = 30'd0;
    logic [3:0]      cmd_len = 4'd0;
    logic            req_ready = 1'b1;
    logic            req_valid;
    logic [29:0]     req_addr;
    logic [4:0]      req_len;
    logic [4:0]      req_tag;
    logic            alloc_init;
    logic            alloc_valid;
    logic [5:0]      alloc_tag;
    logic [7:0]      alloc_bufa;
    logic            dealloc_tag = 1'b0;
    logic            dealloc_data = 1'b0;

    int errors = 0;
    int checks = 0;

    dlsc_pcie_s6_outbound_read_alloc #(.ADDR(ADDR), .LEN(LEN), .TAG(TAG), .BUFA(BUFA)) dut (
        .clk          (clk),
        .rst          (rst),
        .cmd_ready    (cmd_ready),
        .cmd_valid    (cmd_valid),
        .cmd_addr     (cmd_addr),
        .cmd_len      (cmd_len),
        .req_ready    (req_ready),
        .req_valid    (req_valid),
        .req_addr     (req_addr),
        .req_len      (req_len),
        .req_tag      (req_tag),
        .alloc_init   (alloc_init),
        .alloc_valid  (alloc_valid),
        .alloc_tag    (alloc_tag),
        .alloc_bufa   (alloc_bufa),
        .dealloc_tag  (dealloc_tag),
        .dealloc_data (dealloc_data)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        cmd_valid = 1'b0; dealloc_tag = 1'b0; dealloc_data = 1'b0; req_ready = 1'b1;
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
    endtask

    // Full command: accept, ALLOC cycle, REQ cycle, back to IDLE
    task automatic issue(input logic [29:0] a, input logic [3:0] l,
                         input logic [5:0] et, input logic [7:0] eb, input string nm);
        int n;
        logic [4:0] el;
        logic [7:0] enb;
        n = 0;
        el = {1'b0, l} + 5'd1;
        enb = eb + {3'b000, el};
        cmd_valid = 1'b1; cmd_addr = a; cmd_len = l; req_ready = 1'b1;
        while (!cmd_ready && n < 50) begin
            step();
            n++;
        end
        checks++;
        if (cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s accept: cmd_ready=%b required 1 within 50 cycles", nm, cmd_ready);
            cmd_valid = 1'b0;
            return;
        end
        step();
        cmd_valid = 1'b0;
        checks++;
        if (alloc_valid !== 1'b1 || alloc_tag !== et || alloc_bufa !== eb) begin
            errors++;
            $display("FAIL %s alloc: valid=%b tag=%h bufa=%h required 1 %h %h",
                     nm, alloc_valid, alloc_tag, alloc_bufa, et, eb);
        end
        step();
        checks++;
        if (req_valid !== 1'b1 || req_addr !== a || req_len !== el || req_tag !== et[4:0]) begin
            errors++;
            $display("FAIL %s req: valid=%b addr=%h len=%0d tag=%0d required 1 %h %0d %0d",
                     nm, req_valid, req_addr, req_len, req_tag, a, el, et[4:0]);
        end
        step();
        checks++;
        if (req_valid !== 1'b0 || alloc_tag !== et + 6'd1 || alloc_bufa !== enb) begin
            errors++;
            $display("FAIL %s after: req_valid=%b tag=%h bufa=%h required 0 %h %h",
                     nm, req_valid, alloc_tag, alloc_bufa, et + 6'd1, enb);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        checks++;
        if (cmd_ready !== 1'b0 || req_valid !== 1'b0 || alloc_valid !== 1'b0 || alloc_init !== 1'b1 ||
            alloc_tag !== 6'd0 || alloc_bufa !== 8'd0 || dut.tag_used_s !== 6'd0 || dut.data_used_s !== 9'd0) begin
            errors++;
            $display("FAIL reset_values: rdy=%b rv=%b av=%b init=%b tag=%h bufa=%h required 0 0 0 1 0 0",
                     cmd_ready, req_valid, alloc_valid, alloc_init, alloc_tag, alloc_bufa);
        end
        rst = 1'b0;
        checks++;
        if (alloc_init !== 1'b1) begin
            errors++;
            $display("FAIL init_hold: alloc_init=%b required 1", alloc_init);
        end
        for (int i = 0; i < 4; i++) begin
            step();
            checks++;
            if (alloc_init !== 1'b0) begin
                errors++;
                $display("FAIL init_release cycle %0d: alloc_init=%b required 0", i, alloc_init);
            end
        end
    endtask

    task automatic test_single();
        do_reset();
        issue(30'h100, 4'd3, 6'd0, 8'd0, "single");
        checks++;
        if (dut.data_used_s !== 9'd4 || dut.tag_used_s !== 6'd1) begin
            errors++;
            $display("FAIL single_used: data=%0d tag=%0d required 4 1", dut.data_used_s, dut.tag_used_s);
        end
    endtask

    task automatic test_tag_exhaust();
        do_reset();
        for (int i = 0; i < 32; i++) begin
            issue(30'(i), 4'd0, 6'(i), 8'(i), "tag_fill");
        end
        cmd_valid = 1'b1; cmd_addr = 30'h55; cmd_len = 4'd0;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (cmd_ready !== 1'b0) begin
                errors++;
                $display("FAIL tag_stall cycle %0d: cmd_ready=%b required 0", i, cmd_ready);
            end
            step();
        end
        cmd_valid = 1'b0;
        dealloc_tag = 1'b1;
        step();
        dealloc_tag = 1'b0;
        issue(30'h55, 4'd0, 6'h20, 8'd32, "tag_wrap");
    endtask

    task automatic test_data_fill();
        do_reset();
        for (int i = 0; i < 16; i++) begin
            issue(30'(i * 16), 4'd15, 6'(i), 8'(i * 16), "data_fill");
        end
        checks++;
        if (dut.data_used_s !== 9'd256) begin
            errors++;
            $display("FAIL data_full: data_used=%0d required 256", dut.data_used_s);
        end
        cmd_valid = 1'b1; cmd_addr = 30'h3FF; cmd_len = 4'd15;
        dealloc_data = 1'b1;
        for (int i = 0; i < 15; i++) begin
            checks++;
            if (cmd_ready !== 1'b0) begin
                errors++;
                $display("FAIL data_stall after %0d frees: cmd_ready=%b required 0", i, cmd_ready);
            end
            step();
        end
        checks++;
        if (cmd_ready !== 1'b0) begin
            errors++;
            $display("FAIL data_stall after 15 frees: cmd_ready=%b required 0", cmd_ready);
        end
        step();
        dealloc_data = 1'b0;
        cmd_valid = 1'b0;
        checks++;
        if (dut.data_used_s !== 9'd240) begin
            errors++;
            $display("FAIL data_freed: data_used=%0d required 240", dut.data_used_s);
        end
        issue(30'h3FF, 4'd15, 6'd16, 8'd0, "data_wrap");
    endtask

    task automatic test_stall();
        do_reset();
        req_ready = 1'b0;
        cmd_valid = 1'b1; cmd_addr = 30'h2A; cmd_len = 4'd2;
        step();
        cmd_addr = 30'h77; cmd_len = 4'd0;
        step();
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (req_valid !== 1'b1 || req_addr !== 30'h2A || req_len !== 5'd3 || req_tag !== 5'd0 ||
                alloc_tag !== 6'd0 || cmd_ready !== 1'b0) begin
                errors++;
                $display("FAIL stall_hold cycle %0d: rv=%b addr=%h len=%0d tag=%0d atag=%h rdy=%b required 1 2a 3 0 0 0",
                         i, req_valid, req_addr, req_len, req_tag, alloc_tag, cmd_ready);
            end
            step();
        end
        req_ready = 1'b1;
        cmd_valid = 1'b0;
        step();
        checks++;
        if (req_valid !== 1'b0 || alloc_tag !== 6'd1 || alloc_bufa !== 8'd3) begin
            errors++;
            $display("FAIL stall_release: rv=%b tag=%h bufa=%h required 0 1 3", req_valid, alloc_tag, alloc_bufa);
        end
    endtask

    task automatic test_simul();
        do_reset();
        issue(30'h0, 4'd15, 6'd0, 8'd0, "simul_a");
        issue(30'h10, 4'd3, 6'd1, 8'd16, "simul_b");
        checks++;
        if (dut.data_used_s !== 9'd20) begin
            errors++;
            $display("FAIL simul_pre: data_used=%0d required 20", dut.data_used_s);
        end
        cmd_valid = 1'b1; cmd_addr = 30'h40; cmd_len = 4'd1;
        step();
        cmd_valid = 1'b0;
        dealloc_data = 1'b1;
        step();
        dealloc_data = 1'b0;
        checks++;
        if (dut.data_used_s !== 9'd21 || dut.tag_used_s !== 6'd3) begin
            errors++;
            $display("FAIL simul_post: data=%0d tag=%0d required 21 3", dut.data_used_s, dut.tag_used_s);
        end
        step();
    endtask

    task automatic test_reset_mid();
        do_reset();
        issue(30'h5, 4'd1, 6'd0, 8'd0, "mid_pre");
        req_ready = 1'b0;
        cmd_valid = 1'b1; cmd_addr = 30'h123; cmd_len = 4'd5;
        step();
        cmd_valid = 1'b0;
        step();
        checks++;
        if (req_valid !== 1'b1 || req_tag !== 5'd1) begin
            errors++;
            $display("FAIL mid_inreq: rv=%b tag=%0d required 1 1", req_valid, req_tag);
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (req_valid !== 1'b0 || alloc_init !== 1'b1 || dut.tag_used_s !== 6'd0 ||
            dut.data_used_s !== 9'd0 || alloc_tag !== 6'd0 || alloc_bufa !== 8'd0) begin
            errors++;
            $display("FAIL mid_async: rv=%b init=%b tu=%0d du=%0d tag=%h bufa=%h required 0 1 0 0 0 0",
                     req_valid, alloc_init, dut.tag_used_s, dut.data_used_s, alloc_tag, alloc_bufa);
        end
        step();
        rst = 1'b0;
        req_ready = 1'b1;
        step();
        issue(30'h9, 4'd2, 6'd0, 8'd0, "post_reset");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single();
        test_tag_exhaust();
        test_data_fill();
        test_stall();
        test_simul();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
